fir_sample_loader: RTL and testbench

Upstream feeder for the FIR core: accepts 8-bit input samples on a valid/ready stream and keeps a sliding window of the last NUM_TAPS samples. It writes that window, oldest first, into the FIR's x buffer in memory through an Avalon-style write master, then raises a start request and waits for the FIR's done handshake. One window is written per accepted sample once the window is full, so each new sample produces exactly one FIR output.

---
 rtl/fir_sample_loader_if.sv | 45 ++++
 rtl/fir_sample_loader.sv | 165 ++++++++++++++++
 tb/tb_fir_sample_loader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_sample_loader_if.sv
// Bus bundle for fir_sample_loader: config slave, sample stream, x-buffer write master, FIR start/done.
interface fir_sample_loader_if;
  logic        iChipSelect_Control;
  logic        iWrite_Control;
  logic        iRead_Control;
  logic [2:0]  iAddress_Control;
  logic [31:0] iData_Control;
  logic [31:0] oData_Control;

  logic [7:0]  iSample_Data;
  logic        iSample_Valid;
  logic        oSample_Ready;

  logic [31:0] oAddress_Master_Write;
  logic        oWrite_Master_Write;
  logic [31:0] oWriteData_Master_Write;
  logic        iWait_Master_Write;

  logic        oStart;
  logic        iDone;

  // Loader side: serves the config bus, consumes samples, masters the memory write port.
  modport master (
    input  iChipSelect_Control, iWrite_Control, iRead_Control, iAddress_Control, iData_Control,
    output oData_Control,
    input  iSample_Data, iSample_Valid,
    output oSample_Ready,
    output oAddress_Master_Write, oWrite_Master_Write, oWriteData_Master_Write,
    input  iWait_Master_Write,
    output oStart,
    input  iDone
  );

  // Environment side: host, sample source, memory and FIR core.
  modport slave (
    output iChipSelect_Control, iWrite_Control, iRead_Control, iAddress_Control, iData_Control,
    input  oData_Control,
    output iSample_Data, iSample_Valid,
    input  oSample_Ready,
    input  oAddress_Master_Write, oWrite_Master_Write, oWriteData_Master_Write,
    output iWait_Master_Write,
    input  oStart,
    output iDone
  );
endinterface

// File: rtl/fir_sample_loader.sv
// Sliding-window sample loader: copies the last NUM_TAPS samples oldest-first into the FIR x buffer,
// then requests a FIR run and waits for its done handshake.
module fir_sample_loader #(
  parameter int unsigned NUM_TAPS    = 8,
  parameter logic [31:0] ADDR_BASE_X = 32'h00000000
) (
  input  logic              iClk,
  input  logic              iRstn,
  fir_sample_loader_if.master bus
);

  localparam int unsigned   PW   = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int unsigned   FW   = $clog2(NUM_TAPS + 1);
  localparam logic [PW-1:0] LAST = PW'(NUM_TAPS - 1);
  localparam logic [FW-1:0] FULL = FW'(NUM_TAPS);
  localparam logic [PW:0]   WRAP = (PW + 1)'(NUM_TAPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_START
  } state_t;

  state_t state, state_next;

  logic [NUM_TAPS-1:0][7:0] win;
  logic [PW-1:0] wp;
  logic [PW-1:0] idx;
  logic [FW-1:0] fill;
  logic [FW-1:0] fill_after;
  logic [31:0]   base_x;
  logic [31:0]   snapshot;
  logic [31:0]   sample_count;
  logic          enable;
  logic          clear_pending;

  logic          cfg_wr;
  logic          cfg_rd;
  logic          sample_ready;
  logic          accept;
  logic          apply_clear;
  logic          word_done;
  logic [PW:0]   rd_sum;
  logic [PW:0]   rd_wrapped;
  logic [PW-1:0] rd_pos;

  assign cfg_wr       = bus.iChipSelect_Control && bus.iWrite_Control;
  assign cfg_rd       = bus.iChipSelect_Control && bus.iRead_Control;
  assign sample_ready = enable && (state == S_IDLE) && !clear_pending;
  assign accept       = bus.iSample_Valid && sample_ready;
  assign word_done    = (state == S_WRITE) && !bus.iWait_Master_Write;
  assign fill_after   = (fill == FULL) ? FULL : fill + 1'b1;

  // A pending clear lands on the first edge the loader is (or becomes) idle; ready is held low
  // meanwhile, so it can never collide with a sample write into the window.
  assign apply_clear  = clear_pending &&
                        ((state == S_IDLE) || ((state == S_START) && bus.iDone));

  // wp points at the oldest sample once the window is full, so word i reads (wp + i) mod NUM_TAPS.
  assign rd_sum       = {1'b0, wp} + {1'b0, idx};
  assign rd_wrapped   = (rd_sum >= WRAP) ? rd_sum - WRAP : rd_sum;
  assign rd_pos       = rd_wrapped[PW-1:0];

  assign bus.oSample_Ready = sample_ready;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next                  = state;
    bus.oWrite_Master_Write     = 1'b0;
    bus.oAddress_Master_Write   = '0;
    bus.oWriteData_Master_Write = '0;
    bus.oStart                  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && (fill_after == FULL)) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        bus.oWrite_Master_Write     = 1'b1;
        bus.oAddress_Master_Write   = snapshot + {{(32 - PW){1'b0}}, idx};
        bus.oWriteData_Master_Write = {24'd0, win[rd_pos]};
        if (word_done && (idx == LAST)) begin
          state_next = S_START;
        end
      end
      S_START: begin
        bus.oStart = 1'b1;
        if (bus.iDone) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      base_x            <= ADDR_BASE_X;
      enable            <= 1'b0;
      clear_pending     <= 1'b0;
      sample_count      <= '0;
      wp                <= '0;
      fill              <= '0;
      idx               <= '0;
      snapshot          <= '0;
      win               <= '0;
      bus.oData_Control <= '0;
    end else begin
      if (cfg_wr) begin
        case (bus.iAddress_Control)
          3'd0:    base_x <= bus.iData_Control;
          3'd1:    enable <= bus.iData_Control[0];
          default: ;
        endcase
      end

      if (cfg_wr && (bus.iAddress_Control == 3'd1) && bus.iData_Control[1]) begin
        clear_pending <= 1'b1;
      end else if (apply_clear) begin
        clear_pending <= 1'b0;
      end

      if (apply_clear) begin
        wp   <= '0;
        fill <= '0;
        win  <= '0;
      end else if (accept) begin
        win[wp] <= bus.iSample_Data;
        wp      <= (wp == LAST) ? '0 : wp + 1'b1;
        fill    <= fill_after;
        if (fill_after == FULL) begin
          idx      <= '0;
          snapshot <= base_x;
        end
      end

      if (accept && (sample_count != '1)) begin
        sample_count <= sample_count + 1'b1;
      end

      if (word_done) begin
        idx <= (idx == LAST) ? '0 : idx + 1'b1;
      end

      if (cfg_rd) begin
        case (bus.iAddress_Control)
          3'd0:    bus.oData_Control <= base_x;
          3'd1:    bus.oData_Control <= {31'd0, enable};
          3'd2:    bus.oData_Control <= {30'd0, (fill == FULL), (state != S_IDLE)};
          3'd3:    bus.oData_Control <= sample_count;
          default: bus.oData_Control <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_sample_loader.sv
// Directed bench for fir_sample_loader: fill, slide, waitrequest, delayed done, clear, reset.
module tb_fir_sample_loader;

  logic iClk;
  logic iRstn;
  fir_sample_loader_if bus ();

  fir_sample_loader #(
    .NUM_TAPS    (8),
    .ADDR_BASE_X (32'h00000000)
  ) dut (
    .iClk  (iClk),
    .iRstn (iRstn),
    .bus   (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int total = 0;
  int bad   = 0;

  // Completed memory writes, start-high cycles and write-high cycles, sampled at each edge.
  logic [31:0] wa [256];
  logic [31:0] wd [256];
  int wn   = 0;
  int wcyc = 0;
  int scyc = 0;

  always @(posedge iClk) begin
    if (bus.oWrite_Master_Write) begin
      wcyc++;
      if (!bus.iWait_Master_Write && wn < 256) begin
        wa[wn] = bus.oAddress_Master_Write;
        wd[wn] = bus.oWriteData_Master_Write;
        wn++;
      end
    end
    if (bus.oStart) scyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    bus.iChipSelect_Control = 1'b1;
    bus.iWrite_Control      = 1'b1;
    bus.iAddress_Control    = a;
    bus.iData_Control       = d;
    tick();
    bus.iChipSelect_Control = 1'b0;
    bus.iWrite_Control      = 1'b0;
  endtask

  task automatic cfg_read(input logic [2:0] a, output logic [31:0] d);
    bus.iChipSelect_Control = 1'b1;
    bus.iRead_Control       = 1'b1;
    bus.iAddress_Control    = a;
    tick();
    bus.iChipSelect_Control = 1'b0;
    bus.iRead_Control       = 1'b0;
    d = bus.oData_Control;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.oSample_Ready !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, bus.oSample_Ready}, 32'd1);
  endtask

  task automatic send_sample(input logic [7:0] v);
    bus.iSample_Data  = v;
    bus.iSample_Valid = 1'b1;
    wait_ready("accept_ready");
    tick();
    bus.iSample_Valid = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int base;
    int cbase;
    int sbase;
    int n;

    iRstn                   = 1'b0;
    bus.iChipSelect_Control = 1'b0;
    bus.iWrite_Control      = 1'b0;
    bus.iRead_Control       = 1'b0;
    bus.iAddress_Control    = '0;
    bus.iData_Control       = '0;
    bus.iSample_Data        = '0;
    bus.iSample_Valid       = 1'b0;
    bus.iWait_Master_Write  = 1'b0;
    bus.iDone               = 1'b1;
    #3;
    chk("rst_flags", {29'd0, bus.oWrite_Master_Write, bus.oStart, bus.oSample_Ready}, 32'd0);
    chk("rst_addr",  bus.oAddress_Master_Write, 32'd0);
    chk("rst_wdata", bus.oWriteData_Master_Write, 32'd0);
    chk("rst_rdata", bus.oData_Control, 32'd0);
    tick();
    tick();
    iRstn = 1'b1;
    tick();

    // Fill: 8 samples, iDone held high
    cfg_write(3'd0, 32'h100);
    cfg_write(3'd1, 32'h1);
    base = wn;
    for (int v = 1; v <= 7; v++) send_sample(8'(v));
    chk("fill_no_writes", 32'(wn - base), 32'd0);
    chk("fill_ready", {31'd0, bus.oSample_Ready}, 32'd1);
    sbase = scyc;
    send_sample(8'd8);
    chk("first_write", {31'd0, bus.oWrite_Master_Write}, 32'd1);
    chk("first_addr", bus.oAddress_Master_Write, 32'h100);
    chk("first_data", bus.oWriteData_Master_Write, 32'd1);
    repeat (8) tick();
    chk("start_rise", {30'd0, bus.oStart, bus.oWrite_Master_Write}, 32'b10);
    tick();
    chk("start_drop_ready", {30'd0, bus.oStart, bus.oSample_Ready}, 32'b01);
    chk("start_cycles", 32'(scyc - sbase), 32'd1);
    chk("fill_nwrites", 32'(wn - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("fill_addr", wa[base + i], 32'h100 + 32'(i));
      chk("fill_data", wd[base + i], 32'd1 + 32'(i));
    end
    cfg_read(3'd2, r);
    chk("status_full", r, 32'h2);
    cfg_read(3'd3, r);
    chk("count_8", r, 32'd8);

    // Slide: sample 9 gives window 2..9
    base = wn;
    send_sample(8'd9);
    wait_ready("slide_done");
    chk("slide_nwrites", 32'(wn - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("slide_addr", wa[base + i], 32'h100 + 32'(i));
      chk("slide_data", wd[base + i], 32'd2 + 32'(i));
    end

    // Waitrequest on word 2 for 3 cycles; window 3..10
    base  = wn;
    cbase = wcyc;
    send_sample(8'd10);
    tick();
    tick();
    chk("wait_addr_pre", bus.oAddress_Master_Write, 32'h102);
    bus.iWait_Master_Write = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wait_hold_addr", bus.oAddress_Master_Write, 32'h102);
      chk("wait_hold_data", bus.oWriteData_Master_Write, 32'd5);
      chk("wait_hold_wr", {31'd0, bus.oWrite_Master_Write}, 32'd1);
    end
    bus.iWait_Master_Write = 1'b0;
    wait_ready("wait_done");
    chk("wait_nwrites", 32'(wn - base), 32'd8);
    chk("wait_write_cycles", 32'(wcyc - cbase), 32'd11);
    chk("wait_word2", wd[base + 2], 32'd5);
    chk("wait_word7", wd[base + 7], 32'd10);

    // Delayed done
    bus.iDone = 1'b0;
    send_sample(8'd11);
    n = 0;
    while (bus.oStart !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("start_seen", {31'd0, bus.oStart}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("done_hold", {30'd0, bus.oStart, bus.oSample_Ready}, 32'b10);
    end
    bus.iDone = 1'b1;
    tick();
    chk("done_release", {30'd0, bus.oStart, bus.oSample_Ready}, 32'b01);

    // Clear while busy; window 5..12 still written intact
    base = wn;
    send_sample(8'd12);
    cfg_write(3'd1, 32'h3);
    chk("clr_busy_write", {31'd0, bus.oWrite_Master_Write}, 32'd1);
    wait_ready("clr_done");
    chk("clr_nwrites", 32'(wn - base), 32'd8);
    chk("clr_word0", wd[base], 32'd5);
    chk("clr_word7", wd[base + 7], 32'd12);
    cfg_read(3'd2, r);
    chk("clr_status", r, 32'h0);
    cfg_read(3'd1, r);
    chk("clr_ctrl_read", r, 32'h1);
    base = wn;
    for (int v = 8'h21; v <= 8'h27; v++) send_sample(8'(v));
    chk("clr_refill_no_writes", 32'(wn - base), 32'd0);
    cfg_read(3'd2, r);
    chk("clr_refill_status", r, 32'h0);
    send_sample(8'h28);
    wait_ready("clr_refill_done");
    chk("clr_refill_nwrites", 32'(wn - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("clr_refill_addr", wa[base + i], 32'h100 + 32'(i));
      chk("clr_refill_data", wd[base + i], 32'h21 + 32'(i));
    end
    cfg_read(3'd3, r);
    chk("count_20", r, 32'd20);

    // Reset at word 4 of window 0x22..0x28,0x30
    send_sample(8'h30);
    repeat (4) tick();
    chk("rstw_addr", bus.oAddress_Master_Write, 32'h104);
    chk("rstw_data", bus.oWriteData_Master_Write, 32'h26);
    #2;
    iRstn = 1'b0;
    #1;
    chk("rstw_flags", {29'd0, bus.oWrite_Master_Write, bus.oStart, bus.oSample_Ready}, 32'd0);
    chk("rstw_addr0", bus.oAddress_Master_Write, 32'd0);
    chk("rstw_wdata0", bus.oWriteData_Master_Write, 32'd0);
    chk("rstw_rdata0", bus.oData_Control, 32'd0);
    #3;
    iRstn = 1'b1;
    tick();
    cfg_read(3'd2, r);
    chk("rstw_status", r, 32'h0);
    cfg_read(3'd3, r);
    chk("rstw_count", r, 32'd0);
    cfg_read(3'd1, r);
    chk("rstw_ctrl", r, 32'd0);
    cfg_read(3'd0, r);
    chk("rstw_base", r, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
